// File: rtl/mem_pkg.sv
// Shared types and constants for the store buffer and its FIFO.
package mem_pkg;

   // Cache-request sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Access-size encodings carried in mask[2:0]; mask[3] selects sign extension
   localparam logic [2:0]  MASK_BYTE = 3'b001;
   localparam logic [2:0]  MASK_HALF = 3'b011;
   localparam logic [2:0]  MASK_WORD = 3'b111;

   // Memory-mapped LED register; stores to it take the normal queued path
   localparam logic [31:0] LED_ADDR  = 32'h0000_2000;

   // One queued store
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular store queue with a parallel word-address match across all valid entries.
module store_fifo
   import mem_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  entry_t        push_entry,
   input  logic          pop,
   output entry_t        head,
   output logic          full,
   output logic          empty,
   output logic [PW:0]   count,
   input  logic [29:0]   match_word,
   output logic          match
);

   entry_t          slots [DEPTH];
   logic [PW-1:0]   head_ptr;
   logic [PW-1:0]   tail_ptr;
   logic [DEPTH-1:0] hit;

   // Pointer and occupancy bookkeeping; push and pop in one cycle leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PW'(1);
         if (pop)  head_ptr <= head_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage needs no reset: occupancy alone decides which slots are live
   always_ff @(posedge clk) begin
      if (push) slots[tail_ptr] <= push_entry;
   end

   // A slot is live when its distance from head is below count; the in-flight head stays live until popped
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      logic [PW-1:0] offs;
      assign offs   = PW'(i) - head_ptr;
      assign hit[i] = ({1'b0, offs} < count) && (slots[i].addr[31:2] == match_word);
   end

   assign match = |hit;
   assign head  = slots[head_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: queues stores, sends loads ahead of non-matching stores, one cache op at a time.
module store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_mask,
   output logic        req_stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        c_memread,
   output logic        c_memwrite,
   output logic [31:0] c_addr,
   output logic [31:0] c_wdata,
   output logic [3:0]  c_mask,
   input  logic        c_stall,
   input  logic [31:0] c_rdata
);

   state_t                   state;
   state_t                   state_next;
   logic                     op_load;
   entry_t                   head;
   entry_t                   push_entry;
   logic                     full;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;
   logic                     conflict;
   logic                     push;
   logic                     pop;
   logic                     load_go;
   logic                     drain_go;
   logic                     rsp_next;

   assign push_entry = '{addr: req_addr, wdata: req_wdata, mask: req_mask};

   store_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .match_word (req_addr[31:2]),
      .match      (conflict)
   );

   // Handshake decisions: a matching load lets the queue drain first; a freed slot admits a store in the same cycle
   always_comb begin
      load_go   = (state == ST_IDLE) && !c_stall && req_read && !conflict;
      drain_go  = (state == ST_IDLE) && !c_stall && !load_go && !empty;
      pop       = (state == ST_BUSY) && !c_stall && !op_load;
      push      = req_write && (!full || pop);
      req_stall = (req_read && (state != ST_DONE)) || (req_write && full && !pop);
   end

   // State register plus registered cache strobes, payload and load response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         op_load    <= 1'b0;
         c_memread  <= 1'b0;
         c_memwrite <= 1'b0;
         c_addr     <= '0;
         c_wdata    <= '0;
         c_mask     <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         state      <= state_next;
         c_memread  <= load_go;
         c_memwrite <= drain_go;
         rsp_valid  <= rsp_next;
         if (load_go) begin
            op_load <= 1'b1;
            c_addr  <= req_addr;
            c_wdata <= req_wdata;
            c_mask  <= req_mask;
         end else if (drain_go) begin
            op_load <= 1'b0;
            c_addr  <= head.addr;
            c_wdata <= head.wdata;
            c_mask  <= head.mask;
         end
         if (rsp_next) rsp_rdata <= c_rdata;
      end
   end

   // Next-state: IDLE waits for an idle cache so an op accepted before reset is never overlapped
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (load_go || drain_go) state_next = ST_ISSUE;
         ST_ISSUE: state_next = ST_BUSY;
         ST_BUSY:  if (!c_stall) state_next = op_load ? ST_DONE : ST_IDLE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output decode: load data is captured as the cache releases, and presented in DONE
   always_comb begin
      rsp_next = (state == ST_BUSY) && !c_stall && op_load;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural cache model and an op/response scoreboard.
module tb_store_buffer;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_read, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_mask;
   logic        req_stall, rsp_valid;
   logic [31:0] rsp_rdata;
   logic        c_memread, c_memwrite;
   logic [31:0] c_addr, c_wdata;
   logic [3:0]  c_mask;
   logic        c_stall;
   logic [31:0] c_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } op_t;

   op_t         exp_q [$];
   logic [31:0] rsp_q [$];
   op_t         mon_op;
   logic [31:0] mon_rsp;

   // cache model state
   logic [31:0] mem [logic [29:0]];
   int          cs_cnt = 0;
   logic [31:0] rd_word = '0;
   logic [31:0] wr_tmp;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_read   (req_read),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_mask   (req_mask),
      .req_stall  (req_stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .c_memread  (c_memread),
      .c_memwrite (c_memwrite),
      .c_addr     (c_addr),
      .c_wdata    (c_wdata),
      .c_mask     (c_mask),
      .c_stall    (c_stall),
      .c_rdata    (c_rdata)
   );

   function automatic logic [31:0] rd_mem(input logic [29:0] w);
      return mem.exists(w) ? mem[w] : 32'hDEAD_BEEF;
   endfunction

   // Cache: busy for two cycles after a strobe, read data valid once it goes idle; unaffected by rst
   assign c_stall = (cs_cnt != 0);
   assign c_rdata = rd_word;
   always @(posedge clk) begin
      if (c_memwrite) begin
         wr_tmp = rd_mem(c_addr[31:2]);
         case (c_mask[2:0])
            MASK_BYTE: wr_tmp[8*c_addr[1:0] +: 8]  = c_wdata[7:0];
            MASK_HALF: wr_tmp[16*c_addr[1]  +: 16] = c_wdata[15:0];
            default:   wr_tmp = c_wdata;
         endcase
         mem[c_addr[31:2]] = wr_tmp;
      end
      if (c_memread) rd_word <= rd_mem(c_addr[31:2]);
      if (c_memread || c_memwrite) cs_cnt <= 2;
      else if (cs_cnt > 0)         cs_cnt <= cs_cnt - 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every cache strobe and every load response must match the next expected item
   always @(negedge clk) begin
      if (c_memread || c_memwrite) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {30'b0, c_memread, c_memwrite}, 32'h0);
         end else begin
            mon_op = exp_q.pop_front();
            chk("strobe_kind", {30'b0, c_memread, c_memwrite}, mon_op.wr ? 32'h1 : 32'h2);
            chk("strobe_addr", c_addr, mon_op.addr);
            chk("strobe_mask", {28'b0, c_mask}, {28'b0, mon_op.mask});
            if (mon_op.wr) chk("strobe_wdata", c_wdata, mon_op.data);
         end
      end
      if (rsp_valid) begin
         if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
         end else begin
            mon_rsp = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_rsp);
         end
      end
   end

   function automatic op_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m);
      op_t o;
      o.wr = wr; o.addr = a; o.data = d; o.mask = m;
      return o;
   endfunction

   // Present a store, count stall cycles, release after the accepting edge
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int stalls);
      int n;
      req_write = 1'b1; req_addr = a; req_wdata = d; req_mask = m;
      stalls = 0; n = 0;
      @(negedge clk);
      while (req_stall && n < 200) begin
         stalls++; n++;
         @(negedge clk);
      end
      if (req_stall) chk("store_timeout", {31'b0, req_stall}, 32'h0);
      @(posedge clk); #1;
      req_write = 1'b0;
   endtask

   // Present a load, count stall cycles until the response cycle
   task automatic do_load(input logic [31:0] a, input logic [3:0] m, output int stalls,
                          output logic vld);
      int n;
      req_read = 1'b1; req_addr = a; req_wdata = '0; req_mask = m;
      stalls = 0; n = 0;
      @(negedge clk);
      while (req_stall && n < 200) begin
         stalls++; n++;
         @(negedge clk);
      end
      if (req_stall) chk("load_timeout", {31'b0, req_stall}, 32'h0);
      vld = rsp_valid;
      @(posedge clk); #1;
      req_read = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int  n;
      logic idle;
      n = 0;
      @(negedge clk);
      idle = (dut.count == 0) && (dut.state == ST_IDLE) && !c_stall;
      while (!idle && n < 500) begin
         n++;
         @(negedge clk);
         idle = (dut.count == 0) && (dut.state == ST_IDLE) && !c_stall;
      end
      chk({tag, "_idle"}, {31'b0, idle}, 32'h1);
      chk({tag, "_all_ops_seen"}, exp_q.size(), 32'h0);
      chk({tag, "_all_rsp_seen"}, rsp_q.size(), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      int   st;
      logic v;
      rst = 1'b1;
      req_read = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_mask = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_req_stall",  {31'b0, req_stall}, 32'h0);
      chk("rst_rsp_valid",  {31'b0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata",  rsp_rdata, 32'h0);
      chk("rst_strobes",    {30'b0, c_memread, c_memwrite}, 32'h0);
      chk("rst_c_addr",     c_addr, 32'h0);
      chk("rst_c_wdata",    c_wdata, 32'h0);
      chk("rst_c_mask",     {28'b0, c_mask}, 32'h0);
      @(posedge clk); #1;

      // single load, idle buffer: 5 stall cycles, response in cycle 5
      exp_q.push_back(mk(1'b0, 32'h4000, 32'h0, 4'b0111));
      rsp_q.push_back(32'hDEAD_BEEF);
      do_load(32'h4000, 4'b0111, st, v);
      chk("load_stalls", st, 32'd5);
      chk("load_rsp_valid", {31'b0, v}, 32'h1);
      repeat (3) @(posedge clk);
      #1 chk("rsp_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
      wait_idle("t1");

      // four stores fill the queue without stalling; the fifth waits for the first pop
      for (int i = 0; i < 5; i++)
         exp_q.push_back(mk(1'b1, 32'h4000 + 4 * i, 32'h1111_0000 + i, 4'b0111));
      for (int i = 0; i < 4; i++) begin
         do_store(32'h4000 + 4 * i, 32'h1111_0000 + i, 4'b0111, st);
         chk($sformatf("store%0d_stalls", i), st, 32'd0);
      end
      do_store(32'h4010, 32'h1111_0004, 4'b0111, st);
      chk("store_full_stalls", st, 32'd1);
      wait_idle("t2");

      // byte store then matching load: write drains first, load sees merged word
      mem.delete();
      exp_q.push_back(mk(1'b1, 32'h4001, 32'h0000_00AB, 4'b0001));
      exp_q.push_back(mk(1'b0, 32'h4000, 32'h0, 4'b0111));
      rsp_q.push_back(32'hDEAD_ABEF);
      do_store(32'h4001, 32'h0000_00AB, 4'b0001, st);
      do_load(32'h4000, 4'b0111, st, v);
      chk("conflict_load_stalls", st, 32'd10);
      wait_idle("t3");

      // non-matching load overtakes a queued store
      exp_q.push_back(mk(1'b0, 32'h6000, 32'h0, 4'b0111));
      exp_q.push_back(mk(1'b1, 32'h5000, 32'h0000_0077, 4'b0111));
      rsp_q.push_back(32'hDEAD_BEEF);
      do_store(32'h5000, 32'h0000_0077, 4'b0111, st);
      do_load(32'h6000, 4'b0111, st, v);
      chk("bypass_load_stalls", st, 32'd5);
      wait_idle("t4");

      // LED store goes through the queue like any other
      exp_q.push_back(mk(1'b1, LED_ADDR, 32'h0000_005A, 4'b0111));
      do_store(LED_ADDR, 32'h0000_005A, 4'b0111, st);
      chk("led_store_stalls", st, 32'd0);
      wait_idle("t5");

      // reset mid-BUSY with two entries: queue discarded, no strobe until the cache frees
      exp_q.push_back(mk(1'b1, 32'h7000, 32'h0000_0001, 4'b0111));
      do_store(32'h7000, 32'h0000_0001, 4'b0111, st);
      do_store(32'h7004, 32'h0000_0002, 4'b0111, st);
      @(posedge clk); #1;
      chk("pre_rst_state", 32'(dut.state), 32'(ST_BUSY));
      chk("pre_rst_count", 32'(dut.count), 32'd2);
      rst = 1'b1;
      #1;
      chk("rst_count", 32'(dut.count), 32'd0);
      chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
      chk("rst_mid_strobes", {30'b0, c_memread, c_memwrite}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(mk(1'b0, 32'h7008, 32'h0, 4'b0111));
      rsp_q.push_back(32'hDEAD_BEEF);
      do_load(32'h7008, 4'b0111, st, v);
      chk("post_rst_load_stalls", st, 32'd6);
      repeat (10) @(posedge clk);
      wait_idle("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline memory stage and the data cache. It queues stores so the pipeline does not wait for them. It issues loads to the cache when their word does not match any queued store, and otherwise drains matching stores first. It drives the cache's `memread`/`memwrite`/`addr`/`write_data`/`sign_mask` inputs and consumes its `clk_stall`/`read_data` outputs.

## Interface
- `DEPTH`, 4: store entries; power of two, ≥2.
- `clk`  in  1  sole clock; everything updates on posedge.
- `rst`  in  1  reset: asynchronous, active-high.
- `req_read`  in  1  load request from the memory stage.
- `req_write`  in  1  store request; never asserted together with `req_read`.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_mask`  in  4  `[3]` sign-extend; `[2:0]` = 001 byte, 011 half, 111 word.
- `req_stall`  out  1  combinational; pipeline holds `req_*` stable while high.
- `rsp_valid`  out  1  one-cycle pulse when load data is returned.
- `rsp_rdata`  out  32  load data; holds its last value.
- `c_memread`, `c_memwrite`  out  1  one-cycle request strobes to the cache.
- `c_addr`  out  32, `c_wdata`  out  32, `c_mask`  out  4  request payload.
- `c_stall`  in  1  cache busy. Low means the cache is idle and will accept a request.
- `c_rdata`  in  32  cache read data; valid in the first cycle `c_stall` is low after a read.

## Operation
- FIFO entry = {addr 32, wdata 32, mask 4}. Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
- Store:
  - If not full, enqueue at the posedge; `req_stall`=0.
  - If full, `req_stall`=1 until a pop frees a slot.
  - Enqueue and pop in the same cycle are both performed; `count` is unchanged.
- Conflict: the load conflicts if any valid entry (including the in-flight head) has `addr[31:2]` == `req_addr[31:2]`.
- Load: `req_stall`=1 from presentation until the DONE cycle. In DONE `req_stall`=0 and `rsp_valid`=1.
- No forwarding: data is always read back from the cache.
- FSM states: IDLE, ISSUE, BUSY, DONE.
  - IDLE: if `c_stall`=0:
    - if a non-conflicting load is pending, latch load payload and set `op_load`=1 → ISSUE;
    - else if `count`>0, latch the head entry and set `op_load`=0 → ISSUE;
    - otherwise stay in IDLE.
    - Loads have priority over draining.
  - ISSUE: `c_memread` = `op_load`, `c_memwrite` = !`op_load`, both registered and high for exactly this cycle → BUSY.
  - BUSY: stay while `c_stall`=1. On `c_stall`=0:
    - load: capture `c_rdata` into `rsp_rdata` → DONE;
    - store: pop head → IDLE.
  - DONE: `rsp_valid`=1 → IDLE.
- Stores to MMIO address 0x2000 (LED) are queued and drained like any other store.
- Reset:
  - Pointers and `count` clear; FSM → IDLE.
  - All `c_*` outputs, `rsp_valid` and `rsp_rdata` go to 0.
  - `req_stall` is 0 whenever no request is asserted.
  - A queued store is discarded. A cache operation already accepted finishes inside the cache; the IDLE check on `c_stall` prevents overlapping it.

## Timing
- Load, no conflict, FSM idle:
  - presented cycle 0, ISSUE cycle 1, BUSY cycles 2–4;
  - `rsp_valid` in cycle 5; pipeline advances at the end of cycle 5. Load-to-use is 5 stall cycles.
- Store drain: IDLE → ISSUE → BUSY×3 → IDLE = 5 cycles per entry; back-to-back drains every 5 cycles.
- Store enqueue: 0 stall cycles when not full.
- A load arriving in ISSUE or BUSY waits for IDLE, then the priority rule applies.
- Conflicting load: waits until every matching entry has popped, adding 5 cycles per older entry drained.

## Structure
- Package `mem_pkg`:
  - FSM state enum;
  - `MASK_BYTE` (3'b001), `MASK_HALF` (3'b011), `MASK_WORD` (3'b111);
  - `LED_ADDR` (32'h2000);
  - entry struct typedef.
- Sub-module `store_fifo`: storage, pointers, count, full/empty, and a parallel word-address match output with one compare per entry, ORed. The FSM stays in `store_buffer`.

## Test plan
- Reset release → all outputs 0, `req_stall`=0. Single load from 0x4000 with a cache model whose word = 0xDEADBEEF, mask 0111 → `rsp_rdata`=0xDEADBEEF and `rsp_valid` in cycle 5.
- Four stores to 0x4000/0x4004/0x4008/0x400C on consecutive cycles → `req_stall`=0 throughout. A fifth store → `req_stall`=1 until the first pop, and the cache sees writes in FIFO order.
- Store byte 0xAB to 0x4001, then immediately load 0x4000 mask 0111 → the write strobe precedes the read strobe. Read data 0xDEADABEF (model applies the byte) is returned.
- One store queued to 0x5000, then a load of 0x6000 → the load issues before the store drains; the store drains afterwards.
- Store to 0x2000 with data 0x5A → the cache sees `c_memwrite` with `c_addr`=0x2000, `c_wdata`=0x5A.
- Assert `rst` mid-BUSY with 2 entries queued → `count`=0 and IDLE immediately. No new strobe until the model's `c_stall` falls.
